// File: rtl/dkong_pkg.sv
// dkong_pkg: shared types and constants for the Donkey Kong ROM download path.
//   state_e       - loader FSM states
//   region_hit_t  - per-byte region/strobe decode result
//   SND_BASE/WAV_BASE, IOCTL_IDX_*, MOD_* codes, mod_onehot() helper
package dkong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_READY = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  typedef struct packed {
    logic main;
    logic snd;
    logic wav;
    logic dl;
  } region_hit_t;

  // Main ROM region starts at 0; its limit and the others' come from the AW params.
  localparam logic [24:0] SND_BASE = 25'h000E000;
  localparam logic [24:0] WAV_BASE = 25'h0010000;

  localparam logic [7:0] IOCTL_IDX_ROM = 8'd0;
  localparam logic [7:0] IOCTL_IDX_MOD = 8'd1;
  localparam logic [7:0] IOCTL_IDX_DIP = 8'd254;

  localparam logic [7:0] MOD_DK         = 8'd0;
  localparam logic [7:0] MOD_DKJR       = 8'd1;
  localparam logic [7:0] MOD_DK3        = 8'd2;
  localparam logic [7:0] MOD_RADARSCOPE = 8'd3;
  localparam logic [7:0] MOD_PESTPLACE  = 8'd4;

  // One-hot {pestplace, radarscope, dk3, dkjr, dk}; unknown codes select nothing.
  function automatic logic [4:0] mod_onehot(input logic [7:0] m);
    case (m)
      MOD_DK:         return 5'b00001;
      MOD_DKJR:       return 5'b00010;
      MOD_DK3:        return 5'b00100;
      MOD_RADARSCOPE: return 5'b01000;
      MOD_PESTPLACE:  return 5'b10000;
      default:        return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/dkong_rom_loader_if.sv
// dkong_rom_loader_if: ioctl download stream in, ROM write/config outputs back.
//   master - hps_io side: drives ioctl_*, observes loader outputs
//   slave  - loader side: samples ioctl_*, drives strobes, config and status
interface dkong_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        main_we;
  logic        snd_we;
  logic        wav_we;
  logic        dl_wr;
  logic [4:0]  mod_sel;
  logic [7:0]  dip_sw0;
  logic        core_reset;
  logic        rom_ready;
  logic        load_err;
  logic [15:0] cksum;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  rom_addr, rom_data, main_we, snd_we, wav_we, dl_wr,
    input  mod_sel, dip_sw0, core_reset, rom_ready, load_err, cksum
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output rom_addr, rom_data, main_we, snd_we, wav_we, dl_wr,
    output mod_sel, dip_sw0, core_reset, rom_ready, load_err, cksum
  );
endinterface

// File: rtl/dkong_region_decode.sv
// dkong_region_decode: combinational index/address -> {main, snd, wav, dl} hits.
//   index_i - ioctl index, addr_i - ioctl byte address, hit_o - decode result
// Only index-0 (ROM) bytes can hit. The three ROM regions are disjoint;
// dl is decoded separately on addr[23:16].
module dkong_region_decode
  import dkong_pkg::*;
#(
  parameter int MAIN_AW = 15,
  parameter int SND_AW  = 12,
  parameter int WAV_AW  = 16
) (
  input  logic [7:0]  index_i,
  input  logic [24:0] addr_i,
  output region_hit_t hit_o
);

  localparam logic [24:0] MAIN_LIM = 25'd1 << MAIN_AW;
  localparam logic [24:0] SND_LIM  = SND_BASE + (25'd1 << SND_AW);
  localparam logic [24:0] WAV_LIM  = WAV_BASE + (25'd1 << WAV_AW);

  logic is_rom;

  always_comb begin
    is_rom     = (index_i == IOCTL_IDX_ROM);
    hit_o.main = is_rom && (addr_i < MAIN_LIM);
    hit_o.snd  = is_rom && (addr_i >= SND_BASE) && (addr_i < SND_LIM);
    hit_o.wav  = is_rom && (addr_i >= WAV_BASE) && (addr_i < WAV_LIM);
    hit_o.dl   = is_rom && (addr_i[23:16] == 8'h00);
  end

endmodule

// File: rtl/dkong_rom_loader.sv
// dkong_rom_loader: ioctl download front-end for the Donkey Kong core.
//   clk_sys - system clock, reset - synchronous active-high
//   bus     - dkong_rom_loader_if.slave (ioctl stream in; ROM strobes,
//             mod_sel, dip_sw0, core_reset, rom_ready, load_err, cksum out)
// Optional: define ROM_LOADER_CKSUM_EN to build the 16-bit image checksum;
// otherwise cksum is tied to 0.
module dkong_rom_loader
  import dkong_pkg::*;
#(
  parameter int MAIN_AW   = 15,
  parameter int SND_AW    = 12,
  parameter int WAV_AW    = 16,
  parameter int MIN_BYTES = 32768,
  parameter int HOLD_CYC  = 16
) (
  input logic              clk_sys,
  input logic              reset,
  dkong_rom_loader_if.slave bus
);

  localparam int          HW        = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [16:0] MIN_CNT   = 17'(MIN_BYTES);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [16:0]   byte_cnt_q, byte_cnt_d;
  region_hit_t   hit;

  logic [15:0] rom_addr_q;
  logic [7:0]  rom_data_q;
  logic        main_we_q, snd_we_q, wav_we_q, dl_wr_q;
  logic [7:0]  mod_q, dip_q;
  logic [4:0]  mod_sel_q;
  logic        core_reset_q, rom_ready_q, load_err_q;

  logic rom_wr, load_enter, acc;

  dkong_region_decode #(
    .MAIN_AW(MAIN_AW),
    .SND_AW (SND_AW),
    .WAV_AW (WAV_AW)
  ) u_decode (
    .index_i(bus.ioctl_index),
    .addr_i (bus.ioctl_addr),
    .hit_o  (hit)
  );

  // acc covers the byte on the entry cycle and the byte that coincides
  // with the download falling edge.
  always_comb begin
    rom_wr     = bus.ioctl_wr && (bus.ioctl_index == IOCTL_IDX_ROM);
    load_enter = bus.ioctl_download && (bus.ioctl_index == IOCTL_IDX_ROM)
                 && (state_q != ST_LOAD);
    acc        = rom_wr && ((state_q == ST_LOAD) || load_enter);
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    byte_cnt_d = byte_cnt_q;

    if (load_enter) begin
      byte_cnt_d = acc ? 17'd1 : 17'd0;
    end else if (acc && (byte_cnt_q != '1)) begin
      byte_cnt_d = byte_cnt_q + 17'd1;
    end

    if (load_enter) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (!bus.ioctl_download) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = (byte_cnt_q >= MIN_CNT) ? ST_READY : ST_ERROR;
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      byte_cnt_q   <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      main_we_q    <= 1'b0;
      snd_we_q     <= 1'b0;
      wav_we_q     <= 1'b0;
      dl_wr_q      <= 1'b0;
      mod_q        <= MOD_DK;
      mod_sel_q    <= 5'b00001;
      dip_q        <= '0;
      core_reset_q <= 1'b1;
      rom_ready_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_cnt_q <= byte_cnt_d;
      if (bus.ioctl_wr) begin
        rom_addr_q <= bus.ioctl_addr[15:0];
        rom_data_q <= bus.ioctl_dout;
      end
      main_we_q <= bus.ioctl_wr && hit.main;
      snd_we_q  <= bus.ioctl_wr && hit.snd;
      wav_we_q  <= bus.ioctl_wr && hit.wav;
      dl_wr_q   <= bus.ioctl_wr && hit.dl;
      if (bus.ioctl_wr && (bus.ioctl_index == IOCTL_IDX_MOD)) begin
        mod_q <= bus.ioctl_dout;
      end
      mod_sel_q <= mod_onehot(mod_q);
      if (bus.ioctl_wr && (bus.ioctl_index == IOCTL_IDX_DIP)
          && (bus.ioctl_addr == 25'd0)) begin
        dip_q <= bus.ioctl_dout;
      end
      core_reset_q <= (state_d != ST_READY);
      rom_ready_q  <= (state_d == ST_READY);
      load_err_q   <= (state_d == ST_ERROR);
    end
  end

`ifdef ROM_LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (load_enter) begin
      cksum_d = acc ? {8'h00, bus.ioctl_dout} : 16'h0000;
    end else if (acc) begin
      cksum_d = cksum_q + {8'h00, bus.ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  assign bus.cksum = cksum_q;
`else
  assign bus.cksum = 16'h0000;
`endif

  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.main_we    = main_we_q;
  assign bus.snd_we     = snd_we_q;
  assign bus.wav_we     = wav_we_q;
  assign bus.dl_wr      = dl_wr_q;
  assign bus.mod_sel    = mod_sel_q;
  assign bus.dip_sw0    = dip_q;
  assign bus.core_reset = core_reset_q;
  assign bus.rom_ready  = rom_ready_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_dkong_rom_loader.sv
// Bench for dkong_rom_loader: expected strobe events (with due cycle) are
// queued as bytes are driven and popped by a negedge monitor.
module tb_dkong_rom_loader;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  dkong_rom_loader_if bus ();

  dkong_rom_loader dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int main_cnt = 0;

  logic [27:0] sb_ev[$];
  int          sb_due[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent model of the region/dl decode for one index-0 byte.
  function automatic logic [27:0] model_ev(input logic [24:0] a, input logic [7:0] d);
    logic m, s, w, l;
    m = (a < 25'h8000);
    s = (a >= 25'hE000) && (a < 25'hF000);
    w = (a >= 25'h10000) && (a < 25'h20000);
    l = (a[23:16] == 8'h00);
    return {m, s, w, l, a[15:0], d};
  endfunction

  always @(negedge clk_sys) begin
    logic [27:0] got;
    got = {bus.main_we, bus.snd_we, bus.wav_we, bus.dl_wr, bus.rom_addr, bus.rom_data};
    if (got[27:24] != 4'b0000) begin
      if (bus.main_we) main_cnt++;
      if (sb_ev.size() == 0) begin
        chk("unexpected_strobe", {4'h0, got}, 32'h0);
      end else begin
        chk("strobe", {4'h0, got}, {4'h0, sb_ev.pop_front()});
        chk("strobe_latency", cyc, sb_due.pop_front());
      end
    end
  end

  // Drives one byte for the coming edge; leaves ioctl_wr high for streaming.
  task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                      input bit drop);
    logic [27:0] ev;
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    if (drop) bus.ioctl_download = 1'b0;
    if (idx == 8'd0 && !reset) begin
      ev = model_ev(a, d);
      if (ev[27:24] != 4'b0000) begin
        sb_ev.push_back(ev);
        sb_due.push_back(cyc + 1);
      end
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic idle();
    bus.ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic start_dl();
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  function automatic logic [7:0] img_byte(input int i, input bit ck);
    if (!ck) return 8'(i) ^ 8'(i >> 8);
    case (i)
      0: return 8'hFF;
      1: return 8'h01;
      2: return 8'h80;
      3: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // n index-0 bytes at 0..n-1; download drops with the last byte.
  task automatic load_rom(input int n, input bit ck);
    start_dl();
    for (int i = 0; i < n; i++) send(8'd0, 25'(i), img_byte(i, ck), i == n - 1);
    bus.ioctl_wr = 1'b0;
  endtask

  // Called right after the drop edge; checks the HOLD length, then the outcome.
  task automatic finish_hold(input string tag, input bit ready);
    repeat (15) @(posedge clk_sys);
    @(negedge clk_sys);
    chk({tag, "_hold_core_reset"}, bus.core_reset, 1'b1);
    chk({tag, "_hold_ready"}, bus.rom_ready, 1'b0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk({tag, "_core_reset"}, bus.core_reset, !ready);
    chk({tag, "_rom_ready"}, bus.rom_ready, ready);
    chk({tag, "_load_err"}, bus.load_err, !ready);
  endtask

  task automatic mod_write(input logic [7:0] v, input logic [4:0] prev, input logic [4:0] exp);
    send(8'd1, 25'd0, v, 1'b0);
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("mod_sel_1cyc", bus.mod_sel, prev);
    @(negedge clk_sys);
    chk("mod_sel_2cyc", bus.mod_sel, exp);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_core_reset", bus.core_reset, 1'b1);
    chk("rst_rom_ready", bus.rom_ready, 1'b0);
    chk("rst_load_err", bus.load_err, 1'b0);
    chk("rst_mod_sel", bus.mod_sel, 5'b00001);
    chk("rst_dip", bus.dip_sw0, 8'h00);
    chk("rst_cksum", bus.cksum, 16'h0000);
    chk("rst_rom_addr", bus.rom_addr, 16'h0000);
    @(posedge clk_sys); #1;

    mod_write(8'h02, 5'b00001, 5'b00100);
    mod_write(8'h07, 5'b00100, 5'b00000);
    mod_write(8'h04, 5'b00000, 5'b10000);

    send(8'd254, 25'd0, 8'h5A, 1'b0);
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("dip_write", bus.dip_sw0, 8'h5A);
    @(posedge clk_sys); #1;
    send(8'd254, 25'd1, 8'hFF, 1'b0);
    idle();
    @(negedge clk_sys);
    chk("dip_other_addr", bus.dip_sw0, 8'h5A);

    // Full image: 32768 main bytes, READY 16 cycles after the drop.
    main_cnt = 0;
    load_rom(32768, 1'b0);
    finish_hold("full", 1'b1);
    chk("full_main_count", main_cnt, 32768);
    chk("full_cksum_off", bus.cksum, 16'h0000);
    chk("sb_drain_full", sb_ev.size(), 0);

    // Restart from READY with out-of-main regions; mod/dip must survive.
    @(posedge clk_sys); #1;
    start_dl();
    @(negedge clk_sys);
    chk("restart_core_reset", bus.core_reset, 1'b1);
    @(posedge clk_sys); #1;
    send(8'd0, 25'h0E005, 8'h11, 1'b0);
    send(8'd0, 25'h10003, 8'h22, 1'b0);
    send(8'd0, 25'h30000, 8'h33, 1'b0);
    send(8'd0, 25'h09000, 8'h44, 1'b1);
    bus.ioctl_wr = 1'b0;
    finish_hold("short4", 1'b0);
    chk("keep_mod_sel", bus.mod_sel, 5'b10000);
    chk("keep_dip", bus.dip_sw0, 8'h5A);
    chk("sb_drain_regions", sb_ev.size(), 0);

    // 100-byte load from ERROR lands back in ERROR.
    @(posedge clk_sys); #1;
    start_dl();
    @(negedge clk_sys);
    chk("reload_err_clear", bus.load_err, 1'b0);
    @(posedge clk_sys); #1;
    for (int i = 0; i < 100; i++) send(8'd0, 25'(i), 8'(i), i == 99);
    bus.ioctl_wr = 1'b0;
    finish_hold("short100", 1'b0);

    // Reset in the middle of a load.
    mod_write(8'h02, 5'b10000, 5'b00100);
    start_dl();
    for (int i = 0; i < 500; i++) send(8'd0, 25'(i), 8'(i + 1), 1'b0);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("midrst_core_reset", bus.core_reset, 1'b1);
    chk("midrst_rom_ready", bus.rom_ready, 1'b0);
    chk("midrst_load_err", bus.load_err, 1'b0);
    chk("midrst_mod_sel", bus.mod_sel, 5'b00001);
    chk("midrst_dip", bus.dip_sw0, 8'h00);
    chk("midrst_rom_addr", bus.rom_addr, 16'h0000);
    chk("midrst_byte_cnt", dut.byte_cnt_q, 17'd0);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("midrst_idle_core_reset", bus.core_reset, 1'b1);
    @(posedge clk_sys); #1;

    // New full load with the checksum pattern.
    load_rom(32768, 1'b1);
    finish_hold("ckload", 1'b1);
`ifdef ROM_LOADER_CKSUM_EN
    chk("cksum", bus.cksum, 16'h0200);
`else
    chk("cksum_off", bus.cksum, 16'h0000);
`endif
    chk("sb_drain_end", sb_ev.size(), 0);

    repeat (4) @(posedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
